priority_read: RTL and testbench

//  Read-side counterpart of the priority-write path. Several requesters share one
//  8-bit register bank read port, and this block arbitrates between them. Requests
//  are latched (sticky) and served one at a time in fixed priority, lowest index first.

---
 rtl/priority_read.sv | 108 ++++++++++
 tb/tb_priority_read.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_read.sv
// Fixed-priority read arbiter: sticky per-requester read requests are served one
// at a time (lowest index first) through a single synchronous register-bank read port.
module priority_read #(
   parameter int INPUT_COUNT = 4,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [INPUT_COUNT-1:0]            rd_req,
   input  logic [INPUT_COUNT*ADDR_WIDTH-1:0] rd_addr,
   output logic                              mem_rd,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   input  logic [7:0]                        mem_data,
   output logic [7:0]                        rd_data,
   output logic [INPUT_COUNT-1:0]            rd_done,
   output logic                              busy
);

   localparam int SEL_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [SEL_W-1:0]       r_sel;
   logic [SEL_W-1:0]       w_sel_next;
   logic [INPUT_COUNT-1:0] r_pend;
   logic [INPUT_COUNT-1:0] w_pend_next;
   logic [INPUT_COUNT-1:0] w_req_all;
   logic [INPUT_COUNT-1:0] w_sel_onehot;
   logic [INPUT_COUNT-1:0] w_others;
   logic                   w_capture;
   logic [ADDR_WIDTH-1:0]  w_addr_arr [INPUT_COUNT];

   function automatic logic [SEL_W-1:0] lowest_idx(input logic [INPUT_COUNT-1:0] v);
      lowest_idx = '0;
      for (int i = INPUT_COUNT - 1; i >= 0; i--) begin
         if (v[i]) lowest_idx = SEL_W'(i);
      end
   endfunction

   for (genvar g = 0; g < INPUT_COUNT; g++) begin : g_addr
      assign w_addr_arr[g] = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
   end

   assign w_req_all    = r_pend | rd_req;
   assign w_sel_onehot = INPUT_COUNT'(1) << r_sel;
   // Requests still waiting once the current one is retired, including same-cycle arrivals.
   assign w_others     = w_req_all & ~w_sel_onehot;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_pend_next  = w_req_all;
      w_capture    = 1'b0;
      case (r_state)
         IDLE: begin
            if (|w_req_all) begin
               w_sel_next   = lowest_idx(w_req_all);
               w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            w_state_next = CAPTURE;
         end
         CAPTURE: begin
            w_capture   = 1'b1;
            w_pend_next = w_others;
            if (|w_others) begin
               w_sel_next   = lowest_idx(w_others);
               w_state_next = ISSUE;
            end else begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_pend  <= '0;
         rd_data <= '0;
         rd_done <= '0;
      end else begin
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
         r_pend  <= w_pend_next;
         rd_done <= w_capture ? w_sel_onehot : '0;
         if (w_capture) rd_data <= mem_data;
      end
   end

   assign mem_rd   = (r_state == ISSUE);
   assign mem_addr = mem_rd ? w_addr_arr[r_sel] : '0;
   assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_priority_read.sv
// Scoreboard bench for priority_read: stimulus pushes expected completions, a
// negedge monitor pops and compares whenever rd_done fires.
module tb_priority_read;

   logic        clk;
   logic        rst_n;
   logic [3:0]  rd_req;
   logic [15:0] rd_addr;
   logic        mem_rd;
   logic [3:0]  mem_addr;
   logic [7:0]  mem_data;
   logic [7:0]  rd_data;
   logic [3:0]  rd_done;
   logic        busy;

   logic [7:0]  mem [16];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          t0;

   typedef struct {
      int         cyc;
      logic [3:0] done;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];

   priority_read #(.INPUT_COUNT(4), .ADDR_WIDTH(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_req  (rd_req),
      .rd_addr (rd_addr),
      .mem_rd  (mem_rd),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .rd_data (rd_data),
      .rd_done (rd_done),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read bank model.
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input logic [3:0] d, input logic [7:0] v);
      exp_t e;
      e.cyc  = c;
      e.done = d;
      e.data = v;
      sb_q.push_back(e);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mem_rd"},   mem_rd,   0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_rd_data"},  rd_data,  0);
      check({tag, "_rd_done"},  rd_done,  0);
      check({tag, "_busy"},     busy,     0);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rd_done !== 4'b0000) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rd_done", rd_done, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rd_done",    rd_done, e.done);
            check("rd_data",    rd_data, e.data);
            check("done_cycle", cyc,     e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      rd_req  = '0;
      rd_addr = '0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[5] = 8'hA5;
      mem[2] = 8'h11;
      mem[7] = 8'h77;
      mem[9] = 8'h99;

      repeat (2) step();
      rst_n = 1'b1;
      step();
      check_idle_outputs("reset");

      // Single read from requester 2.
      rd_addr[8 +: 4] = 4'd5;
      t0 = cyc;
      rd_req = 4'b0100;
      push(t0 + 3, 4'b0100, 8'hA5);
      step();
      rd_req = '0;
      check("single_mem_rd",   mem_rd,   1);
      check("single_mem_addr", mem_addr, 5);
      check("single_busy",     busy,     1);
      repeat (5) step();
      check("single_hold", rd_data, 8'hA5);

      // Simultaneous requests 1 and 3.
      rd_addr[4 +: 4]  = 4'd2;
      rd_addr[12 +: 4] = 4'd7;
      t0 = cyc;
      rd_req = 4'b1010;
      push(t0 + 3, 4'b0010, 8'h11);
      push(t0 + 5, 4'b1000, 8'h77);
      step();
      rd_req = '0;
      repeat (2) step();
      check("simul_busy_c3",     busy,     1);
      check("simul_mem_rd_c3",   mem_rd,   1);
      check("simul_mem_addr_c3", mem_addr, 7);
      repeat (2) step();
      check("simul_busy_c5", busy, 0);
      repeat (2) step();

      // Higher priority arrives after requester 3 is latched.
      rd_addr[0 +: 4] = 4'd9;
      t0 = cyc;
      rd_req = 4'b1000;
      push(t0 + 3, 4'b1000, 8'h77);
      step();
      rd_req = 4'b0001;
      push(t0 + 5, 4'b0001, 8'h99);
      step();
      rd_req = '0;
      repeat (5) step();

      // Re-request: held through the capture edge, then a fresh request.
      t0 = cyc;
      rd_req = 4'b0010;
      push(t0 + 3, 4'b0010, 8'h11);
      push(t0 + 7, 4'b0010, 8'h11);
      repeat (3) step();
      rd_req = '0;
      step();
      rd_req = 4'b0010;
      step();
      rd_req = '0;
      repeat (5) step();

      // Reset during CAPTURE: outputs clear immediately, read is dropped.
      t0 = cyc;
      rd_req = 4'b0100;
      step();
      rd_req = '0;
      step();
      check("rst_cap_busy_before", busy, 1);
      #3 rst_n = 1'b0;
      #1 check_idle_outputs("rst_async");
      repeat (2) step();
      #3 rst_n = 1'b1;
      step();
      check_idle_outputs("rst_rel1");
      step();
      check_idle_outputs("rst_rel2");

      // Reset during ISSUE.
      rd_req = 4'b0001;
      step();
      rd_req = '0;
      check("rst_issue_mem_rd_before", mem_rd, 1);
      #3 rst_n = 1'b0;
      #1;
      check("rst_issue_mem_rd",   mem_rd,   0);
      check("rst_issue_mem_addr", mem_addr, 0);
      check("rst_issue_busy",     busy,     0);
      step();
      #3 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check("post_rst_mem_rd", mem_rd, 0);
         check("post_rst_busy",   busy,   0);
      end

      repeat (3) step();
      check("scoreboard_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
